// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, CTRL bit indices, bus FSM encoding and byte-lane merge for the timer slave
package timer_pkg;
   localparam logic [7:0] TMR_CTRL   = 8'h00;
   localparam logic [7:0] TMR_STATUS = 8'h02;
   localparam logic [7:0] TMR_PRESC  = 8'h04;
   localparam logic [7:0] TMR_RLD_HI = 8'h06;
   localparam logic [7:0] TMR_RLD_LO = 8'h08;
   localparam logic [7:0] TMR_CNT_HI = 8'h0A;
   localparam logic [7:0] TMR_CNT_LO = 8'h0C;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IE   = 2;
   typedef enum logic {ST_IDLE, ST_ACK} bus_state_t;
   function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] new_v, input logic [15:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction
endpackage

// File: rtl/timer_core.sv
// timer_core: 16-bit prescaler feeding a 32-bit down-counter with one-shot or auto-reload
// ports: clk, reset (async, active-high); en/auto from CTRL; start loads reload and zeroes the prescaler;
//        prescale/reload from the register file; count is the live counter; expire pulses on the
//        tick that finds count at zero; clr_en asks the register file to drop EN on a one-shot expiry
module timer_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        auto,
   input  logic        start,
   input  logic [15:0] prescale,
   input  logic [31:0] reload,
   output logic [31:0] count,
   output logic        expire,
   output logic        clr_en
);
   logic [15:0] r_pc;
   logic [31:0] r_count;
   logic        w_tick;
   assign w_tick = en && r_pc == prescale;
   assign expire = w_tick && r_count == '0;
   assign clr_en = expire && !auto;
   assign count  = r_count;
   // pc compares for equality only, so a PRESCALE lowered below pc lets pc run on to the 16-bit wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc    <= '0;
         r_count <= '0;
      end else if (start) begin
         r_pc    <= '0;
         r_count <= reload;
      end else begin
         r_pc <= (!en || w_tick) ? '0 : r_pc + 16'd1;
         if (w_tick) r_count <= r_count != '0 ? r_count - 32'd1 : auto ? reload : r_count;
      end
   end
endmodule

// File: rtl/timer_slave.sv
// timer_slave: memory-mapped 32-bit timer on the CPU device mux, 16-bit big-endian register file
// ports: clk, reset (async, active-high); we/write/addr/uds/lds from the mux; read/ack back to the mux;
//        irq is a registered level interrupt (EXP & IE)
module timer_slave
   import timer_pkg::*;
#(
   parameter int          ADDR_W     = 8,
   parameter logic [31:0] RELOAD_RST = 32'hFFFFFFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [15:0]       write,
   output logic [15:0]       read,
   input  logic [ADDR_W-1:0] addr,
   input  logic              uds,
   input  logic              lds,
   output logic              ack,
   output logic              irq
);
   bus_state_t        r_state, w_next;
   logic              w_commit, w_wr, w_rd, w_start, w_expire, w_clr_en;
   logic [ADDR_W-1:0] w_off;
   logic              w_sel_ctrl, w_sel_status, w_sel_presc, w_sel_rld_hi, w_sel_rld_lo, w_sel_cnt_hi, w_sel_cnt_lo;
   logic [15:0]       w_mask, w_rdata;
   logic [2:0]        w_ctrl_nx;
   logic [31:0]       w_count;
   logic [2:0]        r_ctrl;
   logic              r_exp, r_irq;
   logic [15:0]       r_presc, r_shadow, r_read;
   logic [31:0]       r_reload;
   // the access commits only on the IDLE->ACK edge, so a held strobe never writes twice
   always_comb begin
      w_commit = r_state == ST_IDLE && (uds || lds);
      ack      = r_state == ST_ACK;
      w_next   = w_commit ? ST_ACK : (ack && !(uds || lds)) ? ST_IDLE : r_state;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end
   assign w_wr         = w_commit && we;
   assign w_rd         = w_commit && !we;
   assign w_off        = addr & ~ADDR_W'(1);
   assign w_sel_ctrl   = w_off == ADDR_W'(TMR_CTRL);
   assign w_sel_status = w_off == ADDR_W'(TMR_STATUS);
   assign w_sel_presc  = w_off == ADDR_W'(TMR_PRESC);
   assign w_sel_rld_hi = w_off == ADDR_W'(TMR_RLD_HI);
   assign w_sel_rld_lo = w_off == ADDR_W'(TMR_RLD_LO);
   assign w_sel_cnt_hi = w_off == ADDR_W'(TMR_CNT_HI);
   assign w_sel_cnt_lo = w_off == ADDR_W'(TMR_CNT_LO);
   assign w_mask       = {{8{uds}}, {8{lds}}};
   assign w_ctrl_nx    = (r_ctrl & ~w_mask[2:0]) | (write[2:0] & w_mask[2:0]);
   assign w_start      = w_wr && w_sel_ctrl && !r_ctrl[CTRL_EN] && w_ctrl_nx[CTRL_EN];
   assign w_rdata      = w_sel_ctrl   ? {13'b0, r_ctrl} :
                         w_sel_status ? {15'b0, r_exp} :
                         w_sel_presc  ? r_presc :
                         w_sel_rld_hi ? r_reload[31:16] :
                         w_sel_rld_lo ? r_reload[15:0] :
                         w_sel_cnt_hi ? w_count[31:16] :
                         w_sel_cnt_lo ? r_shadow : '0;
   timer_core u_core (
      .clk      (clk),
      .reset    (reset),
      .en       (r_ctrl[CTRL_EN]),
      .auto     (r_ctrl[CTRL_AUTO]),
      .start    (w_start),
      .prescale (r_presc),
      .reload   (r_reload),
      .count    (w_count),
      .expire   (w_expire),
      .clr_en   (w_clr_en)
   );
   // CPU write to CTRL beats a one-shot clearing EN; a fresh expiry beats a W1C of EXP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctrl   <= '0;
         r_exp    <= 1'b0;
         r_presc  <= '0;
         r_reload <= RELOAD_RST;
         r_shadow <= '0;
         r_read   <= '0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr && w_sel_ctrl) r_ctrl <= w_ctrl_nx;
         else if (w_clr_en)      r_ctrl[CTRL_EN] <= 1'b0;
         r_exp <= w_expire || (r_exp && !(w_wr && w_sel_status && lds && write[0]));
         if (w_wr && w_sel_presc)  r_presc <= lane_merge(r_presc, write, w_mask);
         if (w_wr && w_sel_rld_hi) r_reload[31:16] <= lane_merge(r_reload[31:16], write, w_mask);
         if (w_wr && w_sel_rld_lo) r_reload[15:0] <= lane_merge(r_reload[15:0], write, w_mask);
         // reading COUNT_HI freezes the low half so the following COUNT_LO read cannot tear
         if (w_rd && w_sel_cnt_hi) r_shadow <= w_count[15:0];
         if (w_commit) r_read <= w_rdata;
         r_irq <= r_exp && r_ctrl[CTRL_IE];
      end
   end
   assign read = r_read;
   assign irq  = r_irq;
endmodule
